// File: rtl/execute_writeback_stage.sv
// ---------------------------------------------------------------------------
// execute_writeback_stage
//
// Third pipeline stage. Executes the instruction presented by the registered
// decode outputs: single-cycle ALU ops, a multi-cycle shift-add multiply and
// LOAD/STORE against an internal data memory. It produces the register-file
// writeback strobe/data and a stall back to fetch/decode.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   opcode     decoded opcode (4'b0000 = NOP / bubble)
//   destReg    destination register index
//   srcVal1    operand 1 (data to store for STORE)
//   srcVal2    operand 2
//   memAddr    LOAD/STORE word address
//   used1/2    operand 1/2 is stale (producer still in flight)
//   stall      hold fetch/decode this cycle (combinational)
//   wbEn       one-cycle register-file write strobe
//   wbReg      writeback register index (holds when wbEn=0)
//   wbVal      writeback data (holds when wbEn=0)
//   zeroFlag   last ALU/MUL result was zero
//   carryFlag  carry/borrow of last ADD/SUB/INC/DEC
//   busy       multiplier is running
// ---------------------------------------------------------------------------
module execute_writeback_stage #(
  parameter int DMEM_DEPTH = 256,
  parameter int MUL_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic [3:0]  destReg,
  input  logic [15:0] srcVal1,
  input  logic [15:0] srcVal2,
  input  logic [7:0]  memAddr,
  input  logic        used1,
  input  logic        used2,
  output logic        stall,
  output logic        wbEn,
  output logic [3:0]  wbReg,
  output logic [15:0] wbVal,
  output logic        zeroFlag,
  output logic        carryFlag,
  output logic        busy
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_NOT   = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_INC   = 4'b1100;
  localparam logic [3:0] OP_DEC   = 4'b1101;
  localparam logic [3:0] OP_LOAD  = 4'b1110;
  localparam logic [3:0] OP_STORE = 4'b1111;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       mcand_q, mcand_d;
  logic [15:0]       mplier_q, mplier_d;
  logic [15:0]       acc_q, acc_d;
  logic [3:0]        mul_reg_q, mul_reg_d;
  logic              wb_en_q, wb_en_d;
  logic [3:0]        wb_reg_q, wb_reg_d;
  logic [15:0]       wb_val_q, wb_val_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;

  logic [15:0] dmem [DMEM_DEPTH];
  logic [15:0] mem_rdata;
  logic        mem_we;

  logic        reads1, reads2, hazard;
  logic [16:0] add17, inc17;
  logic [15:0] alu_r, mul_step;
  logic        alu_wr, alu_cw, alu_c, stall_c;

  // Operand-usage table: which source operands each opcode actually reads.
  always_comb begin
    reads1 = 1'b0;
    reads2 = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SLT, OP_MUL: begin
        reads1 = 1'b1;
        reads2 = 1'b1;
      end
      OP_NOT, OP_INC, OP_DEC, OP_STORE: reads1 = 1'b1;
      default: ;
    endcase
  end

  assign hazard    = (used1 && reads1) || (used2 && reads2);
  assign add17     = {1'b0, srcVal1} + {1'b0, srcVal2};
  assign inc17     = {1'b0, srcVal1} + 17'd1;
  assign mem_rdata = dmem[memAddr];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    mul_reg_d = mul_reg_q;
    wb_en_d   = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_val_d  = wb_val_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    mem_we    = 1'b0;
    stall_c   = 1'b0;
    alu_r     = 16'd0;
    alu_wr    = 1'b0;
    alu_cw    = 1'b0;
    alu_c     = 1'b0;
    mul_step  = 16'd0;
    case (state_q)
      IDLE: begin
        if (hazard) begin
          stall_c = 1'b1;
        end else begin
          case (opcode)
            OP_ADD: begin alu_r = add17[15:0]; alu_c = add17[16]; alu_cw = 1'b1; alu_wr = 1'b1; end
            OP_SUB: begin alu_r = srcVal1 - srcVal2; alu_c = srcVal1 < srcVal2; alu_cw = 1'b1; alu_wr = 1'b1; end
            OP_AND: begin alu_r = srcVal1 & srcVal2; alu_wr = 1'b1; end
            OP_OR:  begin alu_r = srcVal1 | srcVal2; alu_wr = 1'b1; end
            OP_XOR: begin alu_r = srcVal1 ^ srcVal2; alu_wr = 1'b1; end
            OP_NOT: begin alu_r = ~srcVal1; alu_wr = 1'b1; end
            OP_SLL: begin alu_r = srcVal1 << srcVal2[3:0]; alu_wr = 1'b1; end
            OP_SRL: begin alu_r = srcVal1 >> srcVal2[3:0]; alu_wr = 1'b1; end
            OP_SLT: begin alu_r = {15'd0, srcVal1 < srcVal2}; alu_wr = 1'b1; end
            OP_INC: begin alu_r = inc17[15:0]; alu_c = inc17[16]; alu_cw = 1'b1; alu_wr = 1'b1; end
            OP_DEC: begin alu_r = srcVal1 - 16'd1; alu_c = (srcVal1 == 16'd0); alu_cw = 1'b1; alu_wr = 1'b1; end
            OP_MUL: begin
              // Hold decode in the accept cycle; operands are latched here.
              state_d   = MUL_BUSY;
              cnt_d     = '0;
              acc_d     = 16'd0;
              mcand_d   = srcVal1;
              mplier_d  = srcVal2;
              mul_reg_d = destReg;
              stall_c   = 1'b1;
            end
            OP_LOAD: begin
              wb_en_d  = 1'b1;
              wb_reg_d = destReg;
              wb_val_d = mem_rdata;
            end
            OP_STORE: mem_we = 1'b1;
            default: ;
          endcase
          if (alu_wr) begin
            wb_en_d  = 1'b1;
            wb_reg_d = destReg;
            wb_val_d = alu_r;
            zero_d   = (alu_r == 16'd0);
          end
          if (alu_cw) carry_d = alu_c;
        end
      end
      MUL_BUSY: begin
        // One multiplier bit per cycle; only the low 16 product bits are kept.
        mul_step = mplier_q[0] ? mcand_q : 16'd0;
        acc_d    = acc_q + mul_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Stall drops in the final cycle so decode advances on the same
          // edge that retires the product, and the MUL is not re-accepted.
          wb_en_d  = 1'b1;
          wb_reg_d = mul_reg_q;
          wb_val_d = acc_d;
          zero_d   = (acc_d == 16'd0);
          state_d  = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= 16'd0;
      mplier_q  <= 16'd0;
      acc_q     <= 16'd0;
      mul_reg_q <= 4'd0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= 4'd0;
      wb_val_q  <= 16'd0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      mul_reg_q <= mul_reg_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_val_q  <= wb_val_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
    end
  end

  // Data memory is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) dmem[memAddr] <= srcVal1;
  end

  assign stall     = stall_c;
  assign wbEn      = wb_en_q;
  assign wbReg     = wb_reg_q;
  assign wbVal     = wb_val_q;
  assign zeroFlag  = zero_q;
  assign carryFlag = carry_q;
  assign busy      = (state_q == MUL_BUSY);

endmodule

// File: doc/execute_writeback_stage.md
Name: execute_writeback_stage

Overview:
- Third pipeline stage. Consumes the registered decode outputs: opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2.
- Performs ALU ops, multi-cycle multiply, and LOAD/STORE against an internal data memory.
- Drives register-file writeback and a stall back to fetch/decode.
- A bubble is opcode 4'b0000 (NOP); decode emits this on reset.

Parameters:
- DMEM_DEPTH, 256, data memory words (addressed by 8-bit memAddr).
- MUL_CYCLES, 16, busy cycles for MUL (shift-add, one multiplier bit per cycle).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- opcode  in  4  decoded opcode.
- destReg  in  4  destination register (LOAD: already remapped by decode).
- srcVal1  in  16  operand 1 (STORE: data to store).
- srcVal2  in  16  operand 2.
- memAddr  in  8  LOAD/STORE address.
- used1  in  1  operand 1 stale (register in flight).
- used2  in  1  operand 2 stale.
- stall  out  1  hold fetch/decode this cycle.
- wbEn  out  1  register-file write strobe.
- wbReg  out  4  writeback register index.
- wbVal  out  16  writeback data.
- zeroFlag  out  1  last ALU/MUL result == 0.
- carryFlag  out  1  carry/borrow of last ADD/SUB/INC/DEC.
- busy  out  1  FSM in MUL_BUSY.

Behaviour:
Reset (rst=0, async):
- All outputs 0.
- FSM goes to IDLE; multiplier registers cleared.
- Data memory contents are not cleared.

Opcodes:
- 0000 NOP.
- 0001 ADD: s1+s2.
- 0010 SUB: s1-s2.
- 0011 AND.
- 0100 OR.
- 0101 XOR.
- 0110 NOT: ~s1.
- 0111 SLL: s1<<s2[3:0].
- 1000 SRL: s1>>s2[3:0], logical.
- 1001 SLT: unsigned, result 1 if s1<s2 else 0.
- 1010 MUL: low 16 bits of s1*s2.
- 1011 reserved: treated as NOP.
- 1100 INC: s1+1.
- 1101 DEC: s1-1.
- 1110 LOAD: wbVal=dmem[memAddr].
- 1111 STORE: dmem[memAddr]=s1, no writeback.

Operand use:
- Binary ops (0001-0101, 0111-1010) read both operands.
- NOT, INC, DEC and STORE read operand 1 only.
- LOAD and NOP read none.
- Hazard = used1 asserted and operand 1 is read, OR used2 asserted and operand 2 is read.

FSM states: IDLE, MUL_BUSY.
- IDLE + hazard:
  - stall=1 (combinational); wbEn=0 next edge; no memory write; flags unchanged.
  - Re-evaluated every cycle with the current inputs.
- IDLE, no hazard, non-MUL:
  - Result registered in one cycle.
  - At the next rising edge: wbEn=1 (0 for NOP/STORE/1011), wbReg=destReg, wbVal=result.
  - stall=0.
- IDLE, no hazard, MUL:
  - Latch s1, s2, destReg; go to MUL_BUSY.
  - stall=1 and busy=1 from the cycle after acceptance until completion.
  - stall also high combinationally in the accept cycle so decode holds.
- MUL_BUSY:
  - Counter runs 0..MUL_CYCLES-1, one add-shift per cycle.
  - On the last count: wbEn=1 with the product; FSM returns to IDLE; stall drops the same cycle.
  - Inputs are ignored while busy.
- wbEn is a single-cycle pulse per retired writing instruction.
- wbReg/wbVal hold their last value when wbEn=0.

Arithmetic and flags:
- All arithmetic is 16-bit with wrap-around.
- carryFlag = bit 16 of ADD/INC, or borrow (s1<s2, s1==0 for DEC) of SUB/DEC. Other ops leave carryFlag unchanged.
- zeroFlag is updated by every writing ALU/MUL op; unchanged by LOAD/STORE/NOP.

Memory:
- Synchronous write and synchronous read.
- LOAD data is registered at the same edge as wbEn, so LOAD latency is 1 cycle, same as ALU.
- STORE then LOAD to the same address in consecutive cycles returns the new data (write-first).

Reset mid-MUL:
- Aborts: no writeback, FSM goes to IDLE, stall=0.

Test Plan:
1. ADD s1=40, s2=50, destReg=3, used=0 -> next edge: wbEn=1, wbReg=3, wbVal=90, zeroFlag=0, carryFlag=0, stall=0.
2. SUB s1=5, s2=7 -> wbVal=16'hFFFE, carryFlag=1. Then ADD 16'hFFFF+1 -> wbVal=0, zeroFlag=1, carryFlag=1.
3. ADD with used1=1 for 3 cycles, then 0 -> stall=1 and wbEn=0 for 3 cycles; then one wbEn pulse with the correct sum. Separately, NOT with used2=1 -> no stall.
4. MUL 300*7, destReg=5 -> busy/stall high for 16 cycles, then wbVal=2100, wbReg=5, single wbEn. MUL 16'h0100*16'h0100 -> wbVal=0, zeroFlag=1.
5. STORE s1=16'hABCD, memAddr=8'h3C, followed immediately by LOAD memAddr=8'h3C, destReg=9 -> STORE cycle wbEn=0; LOAD cycle wbEn=1, wbReg=9, wbVal=16'hABCD.
6. Assert rst=0 mid-MUL (cycle 8) -> all outputs 0 asynchronously; no writeback after release. Then STORE/LOAD confirms memory retained 16'hABCD.
